mmult_opt_mdc_out_collector: RTL and testbench

- Receiving end of the engine's out_r source stream.
- Accepts result beats under valid/ready, buffers them in a small FIFO and forwards them to the downstream TCDM store streamer.
- Counts accepted beats against a programmed job length and raises a done pulse when the last beat has left the FIFO.
- Sits between the engine's out_r_o port and the sink streamer inside the HWPE wrapper.

---
 rtl/mmult_opt_mdc_out_collector.sv | 167 ++++++++++++++++
 tb/tb_mmult_opt_mdc_out_collector.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmult_opt_mdc_out_collector.sv
// Output collector: accepts engine result beats, buffers them in a small FWFT FIFO
// and forwards them to the store streamer. Optional checksum: MMULT_OPT_MDC_OUT_COLLECTOR_CHECKSUM_EN.
module mmult_opt_mdc_out_collector #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                start_i,
  input  logic [CNT_W-1:0]    len_i,
  input  logic [DATA_W-1:0]   in_data_i,
  input  logic [DATA_W/8-1:0] in_strb_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  output logic [DATA_W-1:0]   out_data_o,
  output logic [DATA_W/8-1:0] out_strb_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [CNT_W-1:0]    cnt_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
`ifdef MMULT_OPT_MDC_OUT_COLLECTOR_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]   checksum_o
`endif
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned FW     = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   len;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [DATA_W-1:0]  data_mem [FIFO_DEPTH];
  logic [STRB_W-1:0]  strb_mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [FW-1:0]      fill;
  logic [FW-1:0]      fill_nxt;
  logic               abort;
  logic               push;
  logic               pop;
  logic               last_beat;
  logic               stray;
  logic               start_ok;

  assign abort     = rst_i | clear_i;
  assign push      = in_valid_i & in_ready_o;
  assign pop       = out_valid_o & out_ready_i;
  assign last_beat = push && (cnt_o == len - CNT_W'(1));
  assign stray     = in_valid_i && (state != RUN);
  assign start_ok  = (state == IDLE) && start_i;

  // Occupancy after this cycle's push/pop
  always_comb begin
    fill_nxt = fill;
    case ({push, pop})
      2'b10:   fill_nxt = fill + FW'(1);
      2'b01:   fill_nxt = fill - FW'(1);
      default: fill_nxt = fill;
    endcase
  end

  // Next-state and beat counter
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_o;
    case (state)
      IDLE: begin
        if (start_i) begin
          cnt_nxt   = '0;
          state_nxt = (len_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (push) cnt_nxt = cnt_o + CNT_W'(1);
        if (last_beat) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (fill_nxt == '0) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Control state; ready/valid/busy are registered from their next-cycle values
  always_ff @(posedge clk_i) begin
    if (abort) begin
      state       <= IDLE;
      len         <= '0;
      cnt_o       <= '0;
      fill        <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      in_ready_o  <= 1'b0;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt_o       <= cnt_nxt;
      fill        <= fill_nxt;
      in_ready_o  <= (state_nxt == RUN) && (fill_nxt != FW'(FIFO_DEPTH));
      out_valid_o <= (fill_nxt != '0);
      busy_o      <= (state_nxt == RUN) || (state_nxt == DRAIN);
      done_o      <= (state == DONE);
      if (start_ok) len <= len_i;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (start_ok) begin
        err_o <= 1'b0;
      end else if (stray) begin
        err_o <= 1'b1;
      end
    end
  end

  // FIFO storage; stale entries past the pointers are never observed
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem[wr_ptr] <= in_data_i;
      strb_mem[wr_ptr] <= in_strb_i;
    end
  end

  // Head of FIFO, forced to zero while empty so idle outputs stay quiet
  always_comb begin
    out_data_o = '0;
    out_strb_o = '0;
    if (out_valid_o) begin
      out_data_o = data_mem[rd_ptr];
      out_strb_o = strb_mem[rd_ptr];
    end
  end

`ifdef MMULT_OPT_MDC_OUT_COLLECTOR_CHECKSUM_EN
  // Running XOR of accepted beats; pushes only happen in RUN so it freezes in DRAIN
  always_ff @(posedge clk_i) begin
    if (abort) begin
      checksum_o <= '0;
    end else if (start_ok) begin
      checksum_o <= '0;
    end else if (push) begin
      checksum_o <= checksum_o ^ in_data_i;
    end
  end
`endif

endmodule

// File: tb/tb_mmult_opt_mdc_out_collector.sv
// Self-checking bench for mmult_opt_mdc_out_collector: vector table, directed
// corner sequences and randomized jobs against a queue-based reference model.
module tb_mmult_opt_mdc_out_collector;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned STRB_W     = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic              start;
  logic [CNT_W-1:0]  len;
  logic [DATA_W-1:0] in_data;
  logic [STRB_W-1:0] in_strb;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic [STRB_W-1:0] out_strb;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  cnt;
  logic              busy;
  logic              done;
  logic              err;
`ifdef MMULT_OPT_MDC_OUT_COLLECTOR_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  always #5 clk = ~clk;

  mmult_opt_mdc_out_collector #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .clear_i    (clear),
    .start_i    (start),
    .len_i      (len),
    .in_data_i  (in_data),
    .in_strb_i  (in_strb),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .out_data_o (out_data),
    .out_strb_o (out_strb),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .cnt_o      (cnt),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
`ifdef MMULT_OPT_MDC_OUT_COLLECTOR_CHECKSUM_EN
    ,
    .checksum_o (checksum)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a job is "in flight" until all len beats were accepted and
  // the queue has emptied; done_o follows that completion two cycles later.
  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [STRB_W-1:0] s;
  } beat_t;

  beat_t             m_q[$];
  bit                m_job;
  int                m_len;
  int                m_cnt;
  int                m_cd;
  bit                m_err;
  logic [DATA_W-1:0] m_csum;

  function automatic bit m_rdy();
    return m_job && (m_cnt < m_len) && (m_q.size() < FIFO_DEPTH);
  endfunction

  task automatic model_edge();
    bit acc;
    bit popd;
    bit can_start;
    bit strayv;
    if (rst || clear) begin
      m_q.delete();
      m_job  = 0;
      m_len  = 0;
      m_cnt  = 0;
      m_cd   = 0;
      m_err  = 0;
      m_csum = '0;
    end else begin
      acc       = in_valid && m_rdy();
      popd      = (m_q.size() > 0) && out_ready;
      can_start = !m_job && (m_cd != 2);
      strayv    = in_valid && !(m_job && (m_cnt < m_len));
      if (m_cd > 0) m_cd--;
      if (popd) void'(m_q.pop_front());
      if (acc) begin
        m_q.push_back({in_data, in_strb});
        m_cnt++;
        m_csum = m_csum ^ in_data;
      end
      if (can_start && start) begin
        m_cnt  = 0;
        m_err  = 0;
        m_csum = '0;
        if (len == '0) begin
          m_cd = 2;
        end else begin
          m_job = 1;
          m_len = int'(len);
        end
      end else if (strayv) begin
        m_err = 1;
      end
      if (m_job && (m_cnt == m_len) && (m_q.size() == 0)) begin
        m_job = 0;
        m_cd  = 2;
      end
    end
  endtask

  task automatic check_model();
    check("m_in_ready", in_ready, m_rdy());
    check("m_out_valid", out_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      check("m_out_data", out_data, m_q[0].d);
      check("m_out_strb", out_strb, m_q[0].s);
    end
    check("m_cnt", cnt, m_cnt);
    check("m_busy", busy, m_job);
    check("m_done", done, m_cd == 1);
    check("m_err", err, m_err);
`ifdef MMULT_OPT_MDC_OUT_COLLECTOR_CHECKSUM_EN
    check("m_checksum", checksum, m_csum);
`endif
  endtask

  // One clock: model advances on the edge, outputs compared on the falling edge
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic idle_inputs();
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_strb   = '0;
    out_ready = 1'b1;
    clear     = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      tick();
      seen = done;
    end
    check(name, seen, 1'b1);
  endtask

  typedef struct {
    bit                st;
    logic [CNT_W-1:0]  ln;
    bit                v;
    logic [DATA_W-1:0] d;
    bit                e_rdy;
    bit                e_ov;
    logic [DATA_W-1:0] e_od;
    logic [CNT_W-1:0]  e_cnt;
    bit                e_busy;
    bit                e_done;
  } vec_t;

  vec_t        tbl[8];
  logic [DATA_W-1:0] got[$];
  int          acc_n;
  int          abort_at;
  bit          aborted;
  bit          seen;

  initial begin
    // Basic job, out_ready held high; each row lists the outputs after its edge
    tbl[0] = '{1'b1, 16'd4, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  16'd0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 16'd0, 1'b1, 32'h11, 1'b1, 1'b1, 32'h11, 16'd1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 16'd0, 1'b1, 32'h22, 1'b1, 1'b1, 32'h22, 16'd2, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 16'd0, 1'b1, 32'h33, 1'b1, 1'b1, 32'h33, 16'd3, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 16'd0, 1'b1, 32'h44, 1'b0, 1'b1, 32'h44, 16'd4, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 16'd0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  16'd4, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 16'd0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  16'd4, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 16'd0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  16'd4, 1'b0, 1'b0};

    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_cnt", cnt, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);

    for (int i = 0; i < 8; i++) begin
      start    = tbl[i].st;
      len      = tbl[i].ln;
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      in_strb  = STRB_W'(i + 3);
      tick();
      check($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_rdy);
      check($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
      if (tbl[i].e_ov) check($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_od);
      check($sformatf("tbl%0d_cnt", i), cnt, tbl[i].e_cnt);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      check($sformatf("tbl%0d_done", i), done, tbl[i].e_done);
    end

    // Zero length: nothing accepted, done two cycles after start
    idle_inputs();
    start = 1'b1;
    len   = '0;
    tick();
    start = 1'b0;
    check("zl_done_early", done, 1'b0);
    check("zl_in_ready", in_ready, 1'b0);
    tick();
    check("zl_done", done, 1'b1);
    check("zl_cnt", cnt, '0);
    tick();
    check("zl_done_once", done, 1'b0);

    // Stray beat while idle raises a sticky error cleared by the next start
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    tick();
    in_valid = 1'b0;
    check("stray_in_ready", in_ready, 1'b0);
    check("stray_err", err, 1'b1);
    tick();
    tick();
    check("stray_err_held", err, 1'b1);
    start = 1'b1;
    len   = 16'd1;
    tick();
    start = 1'b0;
    check("stray_err_cleared", err, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h5;
    in_strb  = 4'h1;
    tick();
    in_valid = 1'b0;
    wait_done("stray_job_done", 20);

    // Backpressure: FIFO fills to four entries, head held stable, then drains in order
    idle_inputs();
    tick();
    out_ready = 1'b0;
    start     = 1'b1;
    len       = 16'd8;
    tick();
    start = 1'b0;
    acc_n = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1;
      in_data  = 32'h100 + 32'(acc_n);
      in_strb  = STRB_W'(acc_n);
      if (in_ready) acc_n++;
      tick();
      if (out_valid) check("bp_head_stable", out_data, 32'h100);
    end
    check("bp_accepted", acc_n, 4);
    check("bp_in_ready_low", in_ready, 1'b0);
    out_ready = 1'b1;
    got.delete();
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      in_valid = (acc_n < 8);
      in_data  = 32'h100 + 32'(acc_n);
      in_strb  = STRB_W'(acc_n);
      if (in_valid && in_ready) acc_n++;
      if (out_valid) got.push_back(out_data);
      tick();
      seen = done;
    end
    in_valid = 1'b0;
    check("bp_done", seen, 1'b1);
    check("bp_delivered", got.size(), 8);
    for (int i = 0; i < got.size(); i++) check($sformatf("bp_order%0d", i), got[i], 32'h100 + 32'(i));

    // Abort: clear after two of six beats discards the job
    idle_inputs();
    out_ready = 1'b0;
    start     = 1'b1;
    len       = 16'd6;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'hA1;
    tick();
    in_data = 32'hA2;
    tick();
    in_valid = 1'b0;
    clear    = 1'b1;
    tick();
    clear = 1'b0;
    check("ab_out_valid", out_valid, 1'b0);
    check("ab_cnt", cnt, '0);
    check("ab_busy", busy, 1'b0);
    check("ab_in_ready", in_ready, 1'b0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("ab_no_done", done, 1'b0);
    end
    out_ready = 1'b1;
    start     = 1'b1;
    len       = 16'd2;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'hB1;
    tick();
    in_data = 32'hB2;
    tick();
    in_valid = 1'b0;
    wait_done("ab_new_job_done", 20);
    check("ab_new_cnt", cnt, 16'd2);

`ifdef MMULT_OPT_MDC_OUT_COLLECTOR_CHECKSUM_EN
    idle_inputs();
    tick();
    start = 1'b1;
    len   = 16'd3;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'hF0F0_F0F0;
    tick();
    in_data = 32'h0F0F_0F0F;
    tick();
    in_data = 32'h0000_00FF;
    tick();
    in_valid = 1'b0;
    wait_done("cs_done", 20);
    check("cs_value", checksum, 32'hFFFF_FF00);
`endif

    // Randomized jobs with random stalls, stray beats and occasional aborts
    for (int j = 0; j < 40; j++) begin
      idle_inputs();
      start    = 1'b1;
      len      = CNT_W'($urandom_range(0, 9));
      tick();
      start    = 1'b0;
      abort_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 10)) : -1;
      aborted  = 0;
      seen     = 0;
      for (int c = 0; c < 300 && !seen && !aborted; c++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_data   = $urandom;
        in_strb   = STRB_W'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
        clear     = (c == abort_at);
        aborted   = clear;
        tick();
        clear = 1'b0;
        seen  = done;
      end
      if (!aborted) check($sformatf("rnd%0d_done", j), seen, 1'b1);
    end

    idle_inputs();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
